// File: rtl/score_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// score_ctrl_pkg
// Shared definitions for the score controller and the score renderer:
//   - game FSM state encoding
//   - BCD nibble width
//   - default horizontal layout of the digit windows (shared with the renderer)
//   - width of the frame-tick prescaler
// -----------------------------------------------------------------------------
package score_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int BCD_W = 4;

  // Renderer's fixed left edge and digit-to-digit spacing, in scaled columns.
  localparam int X0_DEFAULT    = 28;
  localparam int PITCH_DEFAULT = 5;

  // Prescaler width; large enough for TICK_DIV up to 63.
  localparam int TICK_W = 6;

endpackage

// File: rtl/score_ctrl_bcd_counter.sv
// -----------------------------------------------------------------------------
// bcd_counter
// DIGITS-digit BCD incrementer with synchronous clear. It saturates at all-9s
// and never wraps.
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset (value <= 0)
//   clr    synchronous clear, takes priority over inc
//   inc    add one to the count this cycle
//   value  current count, digit 0 in the low nibble
// -----------------------------------------------------------------------------
module bcd_counter
  import score_ctrl_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  output logic [BCD_W*DIGITS-1:0]   value
);

  localparam int VW = BCD_W * DIGITS;

  logic [VW-1:0] count_q;
  logic [VW-1:0] count_d;
  logic [VW-1:0] count_inc;
  logic          carry;
  logic          saturated;

  // Ripple increment: a digit at 9 rolls to 0 and passes the carry upward.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    count_inc = count_q;
    carry     = 1'b1;
    saturated = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[i*BCD_W +: BCD_W] != 4'd9) begin
        saturated = 1'b0;
      end
      if (carry) begin
        if (count_q[i*BCD_W +: BCD_W] == 4'd9) begin
          count_inc[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          count_inc[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] + 4'd1;
          carry                       = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !saturated) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value = count_q;

endmodule

// File: rtl/score_ctrl.sv
// -----------------------------------------------------------------------------
// score_ctrl
// Game score controller for the single-digit score renderer.
//   - IDLE/RUN/OVER game FSM
//   - BCD score advanced every TICK_DIV frame pulses while running
//   - high score latched once per game, in the first OVER cycle
//   - per-frame display snapshot of score or high score
//   - time-shares the renderer across DIGITS windows starting at X0
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   i_frame_start  one-cycle pulse per frame (vblank)
//   i_start        begin a new game
//   i_game_over    end the current game
//   i_show_hi      level: display the high score instead of the score
//   i_hpos         current pixel column (scaled by CONV)
//   o_num          BCD digit for the renderer
//   o_hpos         column remapped so the selected digit lands at X0
//   o_digit_en     column is inside an enabled (non-leading-zero) window
//   o_score        live score, BCD
//   o_hiscore      high score, BCD
//   o_running      FSM is in RUN
// -----------------------------------------------------------------------------
module score_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int CONV     = 0,
  parameter int DIGITS   = 5,
  parameter int X0       = X0_DEFAULT,
  parameter int PITCH    = PITCH_DEFAULT,
  parameter int TICK_DIV = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_frame_start,
  input  logic                    i_start,
  input  logic                    i_game_over,
  input  logic                    i_show_hi,
  input  logic [9:CONV]           i_hpos,
  output logic [3:0]              o_num,
  output logic [9:CONV]           o_hpos,
  output logic                    o_digit_en,
  output logic [BCD_W*DIGITS-1:0] o_score,
  output logic [BCD_W*DIGITS-1:0] o_hiscore,
  output logic                    o_running
);

  localparam int HW = 10 - CONV;
  localparam int SW = BCD_W * DIGITS;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_t             state_q;
  state_t             state_d;
  logic               start_ok;
  logic               over_ok;
  logic               frame_run;
  logic               score_tick;
  logic [TICK_W-1:0]  tick_q;
  logic               first_over_q;
  logic [SW-1:0]      score;
  logic [SW-1:0]      hiscore_q;
  logic [SW-1:0]      snap_q;

  // ---------------------------------------------------------------------------
  // Game FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    over_ok  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d  = ST_RUN;
          start_ok = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_game_over) begin
          state_d = ST_OVER;
          over_ok = 1'b1;
        end
      end
      ST_OVER: begin
        if (i_start) begin
          state_d  = ST_RUN;
          start_ok = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_running = (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Frame prescaler and score. Game over beats a coincident frame pulse, so
  // the score seen on the RUN->OVER edge is final.
  // ---------------------------------------------------------------------------
  assign frame_run  = (state_q == ST_RUN) && i_frame_start && !i_game_over;
  assign score_tick = frame_run && (tick_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
    end else if (start_ok) begin
      tick_q <= '0;
    end else if (frame_run) begin
      tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
    end
  end

  bcd_counter #(
    .DIGITS (DIGITS)
  ) u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .inc   (score_tick),
    .value (score)
  );

  // ---------------------------------------------------------------------------
  // High score: compared once, in the first OVER cycle. Valid BCD orders the
  // same as plain binary, so a straight unsigned compare is enough.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      first_over_q <= 1'b0;
    end else begin
      first_over_q <= over_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hiscore_q <= '0;
    end else if (first_over_q && (score > hiscore_q)) begin
      hiscore_q <= score;
    end
  end

  // Display snapshot only moves at frame boundaries to avoid mid-frame tearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
    end else if (i_frame_start) begin
      snap_q <= i_show_hi ? hiscore_q : score;
    end
  end

  assign o_score   = score;
  assign o_hiscore = hiscore_q;

  // ---------------------------------------------------------------------------
  // Digit windows: one comparator pair per window. Window 0 is the most
  // significant digit. seen_nz tracks whether any digit at or left of the
  // current window is non-zero, which drives leading-zero suppression.
  // ---------------------------------------------------------------------------
  logic [BCD_W-1:0] nib;
  logic [HW-1:0]    win_lo;
  logic [HW-1:0]    win_hi;
  logic             seen_nz;

  always_comb begin
    o_num      = 4'd0;
    o_hpos     = i_hpos;
    o_digit_en = 1'b0;
    nib        = '0;
    win_lo     = '0;
    win_hi     = '0;
    seen_nz    = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      nib     = snap_q[(DIGITS-1-d)*BCD_W +: BCD_W];
      seen_nz = seen_nz | (nib != 4'd0);
      win_lo  = HW'(X0 + d * PITCH);
      win_hi  = HW'(X0 + (d + 1) * PITCH);
      if ((i_hpos >= win_lo) && (i_hpos < win_hi)) begin
        o_num      = nib;
        o_hpos     = i_hpos - HW'(d * PITCH);
        o_digit_en = seen_nz || (d == DIGITS - 1);
      end
    end
  end

endmodule

// File: tb/tb_score_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_ctrl
// Scoreboard bench for score_ctrl. Stimulus pushes hand-computed expectations
// into a queue; a monitor on the falling edge pops and compares them against
// the DUT outputs. A second, small instance (2 digits, one frame per point)
// exercises saturation at all-9s within a short run.
// -----------------------------------------------------------------------------
module tb_score_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (defaults: 5 digits, TICK_DIV 6, X0 28, PITCH 5)
  logic        rst;
  logic        frame;
  logic        start;
  logic        over;
  logic        show_hi;
  logic [9:0]  hpos;
  logic [3:0]  num;
  logic [9:0]  o_hpos;
  logic        digit_en;
  logic [19:0] score;
  logic [19:0] hiscore;
  logic        running;

  // Saturation instance (2 digits, TICK_DIV 1)
  logic        s_frame;
  logic        s_start;
  logic [3:0]  s_num;
  logic [9:0]  s_hpos;
  logic        s_en;
  logic [7:0]  s_score;
  logic [7:0]  s_hi;
  logic        s_run;

  score_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_frame_start (frame),
    .i_start       (start),
    .i_game_over   (over),
    .i_show_hi     (show_hi),
    .i_hpos        (hpos),
    .o_num         (num),
    .o_hpos        (o_hpos),
    .o_digit_en    (digit_en),
    .o_score       (score),
    .o_hiscore     (hiscore),
    .o_running     (running)
  );

  score_ctrl #(.DIGITS(2), .TICK_DIV(1)) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .i_frame_start (s_frame),
    .i_start       (s_start),
    .i_game_over   (1'b0),
    .i_show_hi     (1'b0),
    .i_hpos        (hpos),
    .o_num         (s_num),
    .o_hpos        (s_hpos),
    .o_digit_en    (s_en),
    .o_score       (s_score),
    .o_hiscore     (s_hi),
    .o_running     (s_run)
  );

  typedef enum {K_SCORE, K_HI, K_RUN, K_NUM, K_HPOS, K_EN, K_SAT, K_SAT_RUN} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] value;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] actual(input kind_t k);
    case (k)
      K_SCORE:   return 32'(score);
      K_HI:      return 32'(hiscore);
      K_RUN:     return 32'(running);
      K_NUM:     return 32'(num);
      K_HPOS:    return 32'(o_hpos);
      K_EN:      return 32'(digit_en);
      K_SAT:     return 32'(s_score);
      K_SAT_RUN: return 32'(s_run);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: compare every pending expectation at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, actual(e.kind), e.value);
    end
  end

  task automatic push_exp(input kind_t k, input logic [31:0] v, input string name);
    exp_t e;
    e.kind  = k;
    e.value = v;
    e.name  = name;
    sb.push_back(e);
  endtask

  // Wait (bounded) until the monitor has consumed every expectation.
  task automatic drain();
    for (int t = 0; t < 4; t++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      check("monitor_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic cyc(input logic f, input logic s, input logic g);
    frame = f;
    start = s;
    over  = g;
    @(posedge clk);
    #1;
    frame = 1'b0;
    start = 1'b0;
    over  = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic scyc(input logic f, input logic s);
    s_frame = f;
    s_start = s;
    @(posedge clk);
    #1;
    s_frame = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic expect_main(input logic [19:0] sc, input logic [19:0] hi,
                             input logic run, input string tag);
    push_exp(K_SCORE, 32'(sc), {tag, "_score"});
    push_exp(K_HI, 32'(hi), {tag, "_hiscore"});
    push_exp(K_RUN, 32'(run), {tag, "_running"});
    drain();
  endtask

  task automatic expect_win(input logic [9:0] hp, input logic en,
                            input logic [3:0] n, input logic [9:0] oh, input string tag);
    hpos = hp;
    push_exp(K_EN, 32'(en), {tag, "_digit_en"});
    push_exp(K_NUM, 32'(n), {tag, "_num"});
    push_exp(K_HPOS, 32'(oh), {tag, "_hpos"});
    drain();
  endtask

  typedef struct {
    logic [9:0] hp;
    logic       en;
    logic [3:0] n;
    logic [9:0] oh;
  } win_vec_t;

  // Sweep of snapshot 0x00305 across the window span.
  win_vec_t sweep[10] = '{
    '{10'd28, 1'b0, 4'd0, 10'd28},
    '{10'd33, 1'b0, 4'd0, 10'd28},
    '{10'd37, 1'b0, 4'd0, 10'd32},
    '{10'd38, 1'b1, 4'd3, 10'd28},
    '{10'd42, 1'b1, 4'd3, 10'd32},
    '{10'd43, 1'b1, 4'd0, 10'd28},
    '{10'd48, 1'b1, 4'd5, 10'd28},
    '{10'd52, 1'b1, 4'd5, 10'd32},
    '{10'd53, 1'b0, 4'd0, 10'd53},
    '{10'd27, 1'b0, 4'd0, 10'd27}
  };

  initial begin
    rst     = 1'b1;
    frame   = 1'b0;
    start   = 1'b0;
    over    = 1'b0;
    show_hi = 1'b0;
    hpos    = 10'd0;
    s_frame = 1'b0;
    s_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    expect_main(20'h0, 20'h0, 1'b0, "reset");
    push_exp(K_SAT, 32'h0, "sat_reset_score");
    drain();

    // Game over in IDLE and frames without start do nothing
    cyc(1'b0, 1'b0, 1'b1);
    frames(10);
    expect_main(20'h0, 20'h0, 1'b0, "idle_frames");
    expect_win(10'd48, 1'b1, 4'd0, 10'd28, "idle_w4");
    expect_win(10'd43, 1'b0, 4'd0, 10'd28, "idle_w3");
    expect_win(10'd38, 1'b0, 4'd0, 10'd28, "idle_w2");
    expect_win(10'd27, 1'b0, 4'd0, 10'd27, "idle_left");

    // Saturation on the 2-digit, one-frame-per-point instance
    scyc(1'b0, 1'b1);
    push_exp(K_SAT_RUN, 32'h1, "sat_running");
    drain();
    repeat (98) scyc(1'b1, 1'b0);
    push_exp(K_SAT, 32'h98, "sat_98");
    drain();
    scyc(1'b1, 1'b0);
    push_exp(K_SAT, 32'h99, "sat_99");
    drain();
    repeat (2) scyc(1'b1, 1'b0);
    push_exp(K_SAT, 32'h99, "sat_hold");
    drain();

    // First game: 12 frames = 2 points
    cyc(1'b0, 1'b1, 1'b0);
    expect_main(20'h0, 20'h0, 1'b1, "start");
    frames(12);
    expect_main(20'h2, 20'h0, 1'b1, "two_points");

    // Start while running is ignored: neither score nor prescaler clears
    frames(3);
    cyc(1'b0, 1'b1, 1'b0);
    frames(3);
    expect_main(20'h3, 20'h0, 1'b1, "start_ignored");

    // BCD ripple 99 -> 100
    frames(576);
    expect_main(20'h99, 20'h0, 1'b1, "score_99");
    frames(6);
    expect_main(20'h100, 20'h0, 1'b1, "score_100");

    // Game over: high score appears one cycle after OVER entry
    cyc(1'b0, 1'b0, 1'b1);
    expect_main(20'h100, 20'h0, 1'b0, "over_entry");
    cyc(1'b0, 1'b0, 1'b0);
    expect_main(20'h100, 20'h100, 1'b0, "hi_latch_100");

    // Mid-game reset clears everything
    cyc(1'b0, 1'b1, 1'b0);
    frames(30);
    expect_main(20'h5, 20'h100, 1'b1, "pre_reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_main(20'h0, 20'h0, 1'b0, "mid_reset");

    // 42 points plus 5 ticks, then game over with a coincident frame
    cyc(1'b0, 1'b1, 1'b0);
    frames(257);
    expect_main(20'h42, 20'h0, 1'b1, "score_42");
    cyc(1'b1, 1'b0, 1'b1);
    expect_main(20'h42, 20'h0, 1'b0, "over_wins");
    cyc(1'b0, 1'b0, 1'b0);
    expect_main(20'h42, 20'h42, 1'b0, "hi_latch_42");
    frames(6);
    expect_main(20'h42, 20'h42, 1'b0, "no_score_in_over");

    // Lower-scoring game leaves the high score alone
    cyc(1'b0, 1'b1, 1'b0);
    expect_main(20'h0, 20'h42, 1'b1, "restart");
    frames(102);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    expect_main(20'h17, 20'h42, 1'b0, "hi_kept_42");

    // Game to 0x305, then snapshot it with a frame in OVER
    cyc(1'b0, 1'b1, 1'b0);
    frames(1830);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    expect_main(20'h305, 20'h305, 1'b0, "hi_latch_305");
    foreach (sweep[i]) begin
      expect_win(sweep[i].hp, sweep[i].en, sweep[i].n, sweep[i].oh,
                 $sformatf("sweep_%0d", sweep[i].hp));
    end

    // show_hi switches the display only at the next frame boundary
    cyc(1'b0, 1'b1, 1'b0);
    frames(72);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    expect_main(20'h12, 20'h305, 1'b0, "score_12");
    expect_win(10'd48, 1'b1, 4'd2, 10'd28, "cur_w4");
    expect_win(10'd43, 1'b1, 4'd1, 10'd28, "cur_w3");
    expect_win(10'd38, 1'b0, 4'd0, 10'd28, "cur_w2");
    show_hi = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    expect_win(10'd38, 1'b0, 4'd0, 10'd28, "hold_w2");
    expect_win(10'd48, 1'b1, 4'd2, 10'd28, "hold_w4");
    cyc(1'b1, 1'b0, 1'b0);
    expect_win(10'd38, 1'b1, 4'd3, 10'd28, "hi_w2");
    expect_win(10'd43, 1'b1, 4'd0, 10'd28, "hi_w3");
    expect_win(10'd48, 1'b1, 4'd5, 10'd28, "hi_w4");

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
- Controls the single-digit score renderer.
- Keeps the game score as a multi-digit BCD counter, advanced by frame ticks while the game runs.
- Latches the high score at game over.
- Time-shares the one digit renderer across DIGITS horizontal windows: per pixel, it presents the digit value and a window-relative horizontal position.
- Sits between the game-state logic / video timing and the score renderer. The renderer's output is ANDed with o_digit_en.

Parameters:
- CONV, 0, low bit of pixel coordinates (coordinate scaling), same meaning as the renderer's CONV.
- DIGITS, 5, number of score digits (1..8).
- X0, 28, renderer's fixed left edge in scaled coordinates.
- PITCH, 5, horizontal distance between digit windows (glyph 4 wide plus 1 gap).
- TICK_DIV, 6, frame_start pulses per score point (1..63).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- i_frame_start  in  1  one-cycle pulse, once per frame during vblank.
- i_start  in  1  pulse: begin a new game.
- i_game_over  in  1  pulse: collision or end of game.
- i_show_hi  in  1  level: display the high score instead of the current score.
- i_hpos  in  [9:CONV]  current pixel column.
- o_num  out  4  BCD digit for the renderer.
- o_hpos  out  [9:CONV]  column remapped so the selected digit lands in [X0, X0+4).
- o_digit_en  out  1  current column is inside an enabled digit window.
- o_score  out  4*DIGITS  live score, BCD, digit 0 in the low nibble.
- o_hiscore  out  4*DIGITS  high score, BCD.
- o_running  out  1  FSM is in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst.
- State on reset: FSM=IDLE, score=0, hiscore=0, display snapshot=0, tick counter=0, o_running=0.
- FSM transitions:
  - IDLE→RUN on i_start.
  - RUN→OVER on i_game_over.
  - OVER→RUN on i_start.
  - i_game_over in IDLE or OVER is ignored.
  - i_start in RUN is ignored.
- Entry into RUN (same edge as i_start is accepted): score←0, tick counter←0.
- Scoring in RUN:
  - Each i_frame_start increments the tick counter.
  - When the tick counter would reach TICK_DIV, it wraps to 0 and the score increments by 1 (BCD ripple, each nibble 0..9).
  - The score saturates at all-9s and never wraps.
- Simultaneous i_game_over and i_frame_start in RUN:
  - Game over wins; there is no increment that cycle.
  - The score at the transition edge is final.
- High score latch:
  - On the RUN→OVER edge, if score > hiscore (unsigned BCD compare), then hiscore←score on the following cycle.
  - The compare and latch is done once per game, in the first OVER cycle.
- Display snapshot:
  - On every i_frame_start, snapshot←(i_show_hi ? hiscore : score), using register values before that edge's update.
  - Display values change only at frame boundaries; there is no mid-frame tearing.
- Digit selection (combinational from i_hpos and the snapshot):
  - Window d (d=0 leftmost = most significant) covers [X0+d*PITCH, X0+(d+1)*PITCH).
  - Inside window d: o_num = snapshot nibble DIGITS-1-d, and o_hpos = i_hpos − d*PITCH.
  - Outside all windows: o_num=0, o_hpos=i_hpos, o_digit_en=0.
  - Implement with a comparator chain; no divider.
- Leading-zero suppression:
  - o_digit_en=0 for a window whose digit and all more significant digits are 0.
  - The least significant window is always enabled when in range, so score 0 shows "0".
- Width rules: all hpos arithmetic is modulo the [9:CONV] width.
- Reset mid-game returns to IDLE, with score and hiscore cleared.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, RUN, OVER).
  - BCD nibble width.
  - Default X0/PITCH layout constants, shared with the renderer instance.
- Sub-module bcd_counter: parameterised DIGITS-digit saturating BCD incrementer with sync clear. It is reusable for any future counters.

Test Plan:
- Reset, then 10 frame_start pulses with no i_start → score=0, o_running=0, snapshot=0, only the window-4 digit enabled, showing 0.
- i_start, then 12 frame_start pulses with TICK_DIV=6 → score=0x00002; o_running=1.
- Score preloaded via frames to 0x00099, then a tick → 0x00100. At 0x99999, a further tick → remains 0x99999.
- RUN with score 0x00042, i_game_over and i_frame_start in the same cycle → score stays 0x00042, hiscore=0x00042 one cycle after OVER entry. Next game ending at 0x00017 → hiscore unchanged.
- Snapshot 0x00305, sweep i_hpos 28..52:
  - hpos 28–37 (windows 0–1) → o_digit_en=0.
  - hpos 38 → o_num=3, o_hpos=28.
  - hpos 43 → o_num=0, o_digit_en=1.
  - hpos 48 → o_num=5, o_hpos=28.
  - hpos 53 → o_digit_en=0.
- i_show_hi=1 in OVER → display changes only at the next i_frame_start, then shows hiscore digits.
